// File: rtl/bus_demux_hold.sv
// Steers one shared bus byte into one of two 1-deep holding registers (A/B),
// each with a full flag and a consumer acknowledge, under a valid/ready handshake.
module bus_demux_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             select,
  input  logic             enable_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             a_full,
  input  logic             a_ack,
  output logic [WIDTH-1:0] b_out,
  output logic             b_full,
  input  logic             b_ack,
  output logic [3:0]       wr_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } dest_state_t;

  dest_state_t a_state, a_state_next;
  dest_state_t b_state, b_state_next;

  logic a_can_take;
  logic b_can_take;
  logic accept;
  logic a_accept;
  logic b_accept;

  // A destination can take a byte when empty or when its consumer drains it this cycle.
  assign a_can_take = (a_state == EMPTY) || a_ack;
  assign b_can_take = (b_state == EMPTY) || b_ack;
  assign wr_ready   = !enable_n && (select ? b_can_take : a_can_take);

  assign accept   = wr_valid && wr_ready;
  assign a_accept = accept && !select;
  assign b_accept = accept &&  select;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state <= EMPTY;
      b_state <= EMPTY;
    end else begin
      a_state <= a_state_next;
      b_state <= b_state_next;
    end
  end

  // A same-destination accept wins over an ack, so the flag stays set for the new byte.
  always_comb begin
    a_state_next = a_state;
    unique case (a_state)
      EMPTY: if (a_accept) a_state_next = FULL;
      FULL:  if (a_ack && !a_accept) a_state_next = EMPTY;
      default: a_state_next = EMPTY;
    endcase
  end

  always_comb begin
    b_state_next = b_state;
    unique case (b_state)
      EMPTY: if (b_accept) b_state_next = FULL;
      FULL:  if (b_ack && !b_accept) b_state_next = EMPTY;
      default: b_state_next = EMPTY;
    endcase
  end

  always_comb begin
    a_full = (a_state == FULL);
    b_full = (b_state == FULL);
  end

  // Data only changes on an accept; acks never clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      if (a_accept) a_out <= bus_in;
      if (b_accept) b_out <= bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= 4'd0;
    end else if (accept) begin
      wr_count <= wr_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_bus_demux_hold.sv
// Directed self-checking bench for bus_demux_hold with hand-computed expectations.
module tb_bus_demux_hold;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       select;
  logic       enable_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] a_out;
  logic       a_full;
  logic       a_ack;
  logic [7:0] b_out;
  logic       b_full;
  logic       b_ack;
  logic [3:0] wr_count;

  int testCount = 0;
  int failCount = 0;

  bus_demux_hold #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_in   (bus_in),
    .select   (select),
    .enable_n (enable_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .a_out    (a_out),
    .a_full   (a_full),
    .a_ack    (a_ack),
    .b_out    (b_out),
    .b_full   (b_full),
    .b_ack    (b_ack),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] bus, input logic sel, input logic en_n,
                               input logic valid, input logic aack, input logic back);
    bus_in   = bus;
    select   = sel;
    enable_n = en_n;
    wr_valid = valid;
    a_ack    = aack;
    b_ack    = back;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ready_in_reset_disabled", {7'd0, wr_ready}, 8'h00);
    stepClock();
    stepClock();
    checkOutput("rst_a_out", a_out, 8'h00);
    checkOutput("rst_b_out", b_out, 8'h00);
    checkOutput("rst_a_full", {7'd0, a_full}, 8'h00);
    checkOutput("rst_b_full", {7'd0, b_full}, 8'h00);
    checkOutput("rst_count", {4'd0, wr_count}, 8'h00);
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ready", {7'd0, wr_ready}, 8'h01);

    // basic steer into A then B
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("steer_a_out", a_out, 8'h5A);
    checkOutput("steer_a_full", {7'd0, a_full}, 8'h01);
    checkOutput("steer_b_full", {7'd0, b_full}, 8'h00);
    checkOutput("steer_count1", {4'd0, wr_count}, 8'h01);
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("steer_b_out", b_out, 8'hC3);
    checkOutput("steer_b_full2", {7'd0, b_full}, 8'h01);
    checkOutput("steer_count2", {4'd0, wr_count}, 8'h02);

    // backpressure on full A, then ack releases it in the same cycle
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_ready_low", {7'd0, wr_ready}, 8'h00);
    stepClock();
    checkOutput("bp_a_held", a_out, 8'h5A);
    checkOutput("bp_count_held", {4'd0, wr_count}, 8'h02);
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_ready_ack", {7'd0, wr_ready}, 8'h01);
    stepClock();
    checkOutput("bp_a_new", a_out, 8'h11);
    checkOutput("bp_a_full_kept", {7'd0, a_full}, 8'h01);
    checkOutput("bp_count3", {4'd0, wr_count}, 8'h03);

    // enable gating for 3 cycles, b_ack honoured in the middle one
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("en_ready_low", {7'd0, wr_ready}, 8'h00);
    stepClock();
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    stepClock();
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("en_b_cleared", {7'd0, b_full}, 8'h00);
    checkOutput("en_b_out_kept", b_out, 8'hC3);
    checkOutput("en_a_out_kept", a_out, 8'h11);
    checkOutput("en_count_kept", {4'd0, wr_count}, 8'h03);

    // ack A empties it but keeps data; then acks on empty destinations do nothing
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    stepClock();
    checkOutput("ack_a_empty", {7'd0, a_full}, 8'h00);
    checkOutput("ack_a_data_kept", a_out, 8'h11);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    stepClock();
    checkOutput("ack_empty_a", {7'd0, a_full}, 8'h00);
    checkOutput("ack_empty_b", {7'd0, b_full}, 8'h00);
    checkOutput("ack_empty_count", {4'd0, wr_count}, 8'h03);

    // clear count, then 16 alternating writes with acks every cycle
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkOutput("rst2_count", {4'd0, wr_count}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(8'h20 + i), i[0], 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("wrap_ready_%0d", i), {7'd0, wr_ready}, 8'h01);
      if (i == 15) checkOutput("wrap_count15", {4'd0, wr_count}, 8'h0F);
      stepClock();
    end
    checkOutput("wrap_count0", {4'd0, wr_count}, 8'h00);
    checkOutput("wrap_a_out", a_out, 8'h2E);
    checkOutput("wrap_b_out", b_out, 8'h2F);
    checkOutput("wrap_a_full", {7'd0, a_full}, 8'h00);
    checkOutput("wrap_b_full", {7'd0, b_full}, 8'h01);

    // fill A so both are full, then reset alongside an accept to B and acks
    applyStimulus(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("mid_a_full", {7'd0, a_full}, 8'h01);
    checkOutput("mid_count", {4'd0, wr_count}, 8'h01);
    rst = 1'b1;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    stepClock();
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_a_out", a_out, 8'h00);
    checkOutput("mid_rst_b_out", b_out, 8'h00);
    checkOutput("mid_rst_a_full", {7'd0, a_full}, 8'h00);
    checkOutput("mid_rst_b_full", {7'd0, b_full}, 8'h00);
    checkOutput("mid_rst_count", {4'd0, wr_count}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/bus_demux_hold.md
# bus_demux_hold

Write-side counterpart of the 8-bit 2:1 source mux. The block takes one shared bus byte and steers it into one of two destination holding registers, A or B. Each destination is a 1-deep buffer with a full flag and a consumer acknowledge. Writes use a valid/ready handshake gated by an active-low enable, so the bus driver stalls while the selected destination is occupied.

## Interface
Parameters:
- `WIDTH`, default 8: data width of the bus and of both holding registers.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `bus_in`, input, WIDTH: shared data bus.
- `select`, input, 1: destination select; 0 = A, 1 = B.
- `enable_n`, input, 1: active-low enable. When high, no write is accepted.
- `wr_valid`, input, 1: the bus driver presents a byte.
- `wr_ready`, output, 1: combinational; the selected destination can accept this cycle.
- `a_out`, output, WIDTH: holding register A.
- `a_full`, output, 1: A holds unconsumed data.
- `a_ack`, input, 1: consumer of A takes the data.
- `b_out`, output, WIDTH: holding register B.
- `b_full`, output, 1: B holds unconsumed data.
- `b_ack`, input, 1: consumer of B takes the data.
- `wr_count`, output, 4: count of accepted writes, wrapping.

## Operation
- `wr_ready = !enable_n && (select ? (!b_full || b_ack) : (!a_full || a_ack))`.
- Accept condition: `wr_valid && wr_ready`. On accept:
  - The selected register loads `bus_in`.
  - Its full flag is set.
  - `wr_count` increments.
- `a_ack` or `b_ack` while that flag is set clears the flag, unless an accept to the same destination happens in the same cycle; then the flag stays 1 and the new data loads.
- An ack while the flag is clear is ignored.
- Ack and accept for different destinations in one cycle act independently.
- Data registers hold their value after ack. Only an accept changes them; ack never clears data.
- When `enable_n` is high, `wr_ready` is 0 and `wr_valid` has no effect. Acks are still honoured.
- While the driver is stalled it holds `bus_in`, `select` and `wr_valid`. The block does not latch an unaccepted request.
- `wr_count` is 4-bit unsigned and wraps 15 → 0 with no flag.
- Per-destination state is EMPTY (full=0) or FULL (full=1):
  - EMPTY → FULL on accept.
  - FULL → EMPTY on ack without a same-destination accept.
  - FULL → FULL on accept together with ack.

## Timing
- Reset values: `a_out` = `b_out` = 0, `a_full` = `b_full` = 0, `wr_count` = 0.
- `wr_ready` is 0 whenever `enable_n` is 1, including during reset.
- Reset is synchronous. An asserted `rst` takes priority over any accept or ack in the same cycle. Mid-operation reset drops any held data on the next edge.
- Latency: data and full flag are visible on the cycle after the accept edge. Accept to consumer visibility is 1 cycle.
- `wr_ready` reacts combinationally to `select`, `enable_n`, `a_ack`, `b_ack` and the full flags. It has no path from `wr_valid`.
- Throughput: one write per cycle to a destination that is acked in the same cycle. Alternating A/B writes also sustain one per cycle while the consumers keep up.

## Test plan
- Reset then idle: after `rst` is held 2 cycles, all outputs are 0, and `wr_ready` = 1 with `enable_n` = 0.
- Basic steer: `bus_in` = 0x5A, `select` = 0, `wr_valid` = 1 for 1 cycle → next cycle `a_out` = 0x5A, `a_full` = 1, `b_full` = 0, `wr_count` = 1. Then `bus_in` = 0xC3, `select` = 1 → `b_out` = 0xC3, `b_full` = 1.
- Backpressure: with A full, request A with `bus_in` = 0x11 → `wr_ready` = 0 and `a_out` stays 0x5A. Pulse `a_ack` with the request held → accept that cycle, and next cycle `a_out` = 0x11 with `a_full` still 1.
- Enable gating: `enable_n` = 1 with `wr_valid` = 1 for 3 cycles → no register or count change. A `b_ack` in that window still clears `b_full`.
- Count wrap and concurrency: 16 accepted writes alternating A/B with acks every cycle → `wr_count` returns to 0 and `wr_ready` stays 1 throughout. An ack on an empty destination changes nothing.
- Reset mid-operation: both destinations full, then `rst` = 1 in the same cycle as an accept and an ack → next cycle all flags, data and count are 0.
